// File: rtl/structure2_fc_pkg.sv
// Shared widths, FSM encoding and FIFO tag layout
// for the FC2 buffer reader.
package structure2_fc_pkg;

  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 18;
  localparam int FIFO_DEPTH = 4;
  localparam int RD_LAT     = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  typedef struct packed {
    logic fin;
    logic last;
  } tag_t;

endpackage

// File: rtl/structure2_fc2skidfifo.sv
// Small synchronous FIFO between the buffer read
// pipeline and the output stream.
module structure2_fc2skidfifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [W-1:0]     i_din,
  input  logic             i_pop,
  output logic [W-1:0]     o_dout,
  output logic [CNT_W-1:0] o_count
);

  localparam int PW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_empty = (r_cnt == '0);
  assign w_pop   = i_pop && !w_empty;
  assign w_push  = i_push && (r_cnt != CNT_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= inc(r_wp);
      if (w_pop)  r_rp <= inc(r_rp);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CNT_W'(1);
      else if (w_pop && !w_push) r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Empty FIFO presents zeros so a flush clears the stream outputs.
  assign o_dout  = w_empty ? '0 : r_mem[r_rp];
  assign o_count = r_cnt;

endmodule

// File: rtl/structure2_fc2bramreader.sv
// FC2 buffer reader: streams a vector from buffer port B,
// re-reading it for a number of passes.
module structure2_fc2bramreader #(
  parameter int ADDR_W     = structure2_fc_pkg::ADDR_W,
  parameter int DATA_W     = structure2_fc_pkg::DATA_W,
  parameter int FIFO_DEPTH = structure2_fc_pkg::FIFO_DEPTH,
  parameter int RD_LAT     = structure2_fc_pkg::RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] vec_len,
  input  logic [7:0]        passes,
  output logic              fc2en,
  output logic [ADDR_W-1:0] fc2dataaddr,
  input  logic [DATA_W-1:0] fc2dataout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_final,
  output logic              busy,
  output logic              done
);

  import structure2_fc_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int FW    = DATA_W + 2;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_widx;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_passes;
  logic [7:0]        r_pidx;
  logic              r_zero;
  logic [RD_LAT-1:0] r_pv;
  tag_t              r_ptag [RD_LAT];
  logic [CNT_W-1:0]  w_cnt;
  logic [FW-1:0]     w_head;
  tag_t              w_htag;
  tag_t              w_tag;
  logic [15:0]       w_occ;
  logic [ADDR_W-1:0] w_addr;
  logic              w_last;
  logic              w_final;
  logic              w_issue;
  logic              w_pop;

  assign w_addr  = r_base + r_widx;
  assign w_last  = (r_widx == r_len - ADDR_W'(1));
  assign w_final = w_last && (r_pidx == r_passes - 8'd1);
  assign w_tag   = '{fin: w_final, last: w_last};

  // Credit check: queued words plus reads still in the pipe.
  always_comb begin
    w_occ = 16'(w_cnt);
    for (int i = 0; i < RD_LAT; i++) begin
      w_occ = w_occ + 16'(r_pv[i]);
    end
  end

  assign w_issue = (r_state == S_READ) && !r_zero
                && (w_occ < 16'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_READ;
      S_READ: begin
        if (r_zero)                  w_next = S_FIN;
        else if (w_issue && w_final) w_next = S_DRAIN;
      end
      S_DRAIN: if (w_pop && w_htag.fin) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base   <= '0;
      r_len    <= '0;
      r_passes <= '0;
      r_zero   <= 1'b0;
      r_widx   <= '0;
      r_pidx   <= '0;
      r_addr   <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_base   <= base_addr;
        r_len    <= vec_len;
        r_passes <= passes;
        r_zero   <= (vec_len == '0) || (passes == 8'd0);
        r_widx   <= '0;
        r_pidx   <= '0;
      end
      if (w_issue) begin
        r_addr <= w_addr;
        if (w_last) begin
          r_widx <= '0;
          r_pidx <= r_pidx + 8'd1;
        end else begin
          r_widx <= r_widx + ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pv <= '0;
      for (int i = 0; i < RD_LAT; i++) r_ptag[i] <= '0;
    end else begin
      r_pv[0]   <= w_issue;
      r_ptag[0] <= w_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i]   <= r_pv[i-1];
        r_ptag[i] <= r_ptag[i-1];
      end
    end
  end

  structure2_fc2skidfifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_pv[RD_LAT-1]),
    .i_din   ({r_ptag[RD_LAT-1], fc2dataout}),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_count (w_cnt)
  );

  assign w_htag      = w_head[FW-1 -: 2];
  assign w_pop       = out_valid && out_ready;
  assign out_valid   = (w_cnt != '0);
  assign out_data    = w_head[DATA_W-1:0];
  assign out_last    = w_htag.last;
  assign out_final   = w_htag.fin;
  assign fc2en       = w_issue;
  assign fc2dataaddr = w_issue ? w_addr : r_addr;
  assign busy        = (r_state == S_READ) || (r_state == S_DRAIN);
  assign done        = (r_state == S_FIN);

endmodule

// File: tb/tb_structure2_fc2bramreader.sv
// Bench for the FC2 buffer reader: queue-based model of the
// expected address and word streams, random and directed runs.
`timescale 1ns/1ps
module tb_structure2_fc2bramreader;

  localparam int AW    = 14;
  localparam int DW    = 18;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] vec_len = '0;
  logic [7:0]    passes = '0;
  logic          fc2en;
  logic [AW-1:0] fc2dataaddr;
  logic [DW-1:0] fc2dataout = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_final;
  logic          busy;
  logic          done;

  structure2_fc2bramreader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .vec_len     (vec_len),
    .passes      (passes),
    .fc2en       (fc2en),
    .fc2dataaddr (fc2dataaddr),
    .fc2dataout  (fc2dataout),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_final   (out_final),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    logic          f;
  } word_t;

  word_t         exp_q[$];
  logic [AW-1:0] addr_q[$];
  logic [AW-1:0] addr_log[$];
  logic          last_log[$];
  logic          fin_log[$];

  int            nchk = 0;
  int            npass = 0;
  int            cyc = 0;
  int            stall_cnt = 0;
  bit            rnd_ready = 0;
  logic [DW-1:0] seed;

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return {a[3:0], a} ^ seed;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Expected streams straight from the pass/word rules.
  task automatic model_load(input int b, input int l, input int np);
    word_t w;
    int    a;
    for (int p = 0; p < np; p++) begin
      for (int i = 0; i < l; i++) begin
        a   = (b + i) % (1 << AW);
        w.d = memf(AW'(a));
        w.l = (i == l - 1);
        w.f = (i == l - 1) && (p == np - 1);
        addr_q.push_back(AW'(a));
        exp_q.push_back(w);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Buffer model: one-cycle read latency.
  initial forever begin
    logic [AW-1:0] ra;
    @(posedge clk);
    if (fc2en) begin
      ra = fc2dataaddr;
      #1 fc2dataout = memf(ra);
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (stall_cnt > 0) begin
      out_ready = 1'b0;
      stall_cnt--;
    end else begin
      out_ready = rnd_ready ? ($urandom_range(0, 9) < 7) : 1'b1;
    end
  end

  initial begin
    logic [AW-1:0]   prev_addr;
    logic            prev_v;
    logic            prev_r;
    logic [DW+1:0]   prev_w;
    logic [AW-1:0]   ea;
    word_t           w;
    int              issued;
    int              accepted;
    prev_addr = '0;
    prev_v    = 1'b0;
    prev_r    = 1'b1;
    prev_w    = '0;
    issued    = 0;
    accepted  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v    = 1'b0;
        prev_addr = fc2dataaddr;
        issued    = 0;
        accepted  = 0;
      end else begin
        if (fc2en) begin
          issued++;
          chk("addr_expected", addr_q.size() > 0, 1);
          if (addr_q.size() > 0) begin
            ea = addr_q.pop_front();
            chk("fc2dataaddr", fc2dataaddr, ea);
          end
          addr_log.push_back(fc2dataaddr);
          chk("outstanding_le_depth", (issued - accepted) <= DEPTH, 1);
        end else begin
          chk("addr_hold", fc2dataaddr, prev_addr);
        end
        if (prev_v && !prev_r) begin
          chk("valid_held", out_valid, 1);
          chk("word_held", {out_final, out_last, out_data}, prev_w);
        end
        if (out_valid) begin
          chk("valid_has_expect", exp_q.size() > 0, 1);
          if (out_ready && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            accepted++;
            chk("out_data", out_data, w.d);
            chk("out_last", out_last, w.l);
            chk("out_final", out_final, w.f);
            last_log.push_back(out_last);
            fin_log.push_back(out_final);
          end
        end
        prev_addr = fc2dataaddr;
        prev_v    = out_valid;
        prev_r    = out_ready;
        prev_w    = {out_final, out_last, out_data};
      end
    end
  end

  task automatic run(input int b, input int l, input int np,
                     input int stall_at, input bit poke,
                     output int t_en, output int t_val,
                     output int t_fin, output int t_done);
    int k;
    t_en = -1; t_val = -1; t_fin = -1; t_done = -1;
    @(negedge clk);
    addr_log.delete();
    last_log.delete();
    fin_log.delete();
    base_addr = AW'(b);
    vec_len   = AW'(l);
    passes    = 8'(np);
    start     = 1'b1;
    k         = cyc;
    if (l > 0 && np > 0) model_load(b, l, np);
    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      if (it == 0) start = 1'b0;
      if (poke && it == 3) begin
        base_addr = AW'(b + 100);
        vec_len   = AW'(7);
        passes    = 8'd3;
        start     = 1'b1;
      end
      if (poke && it == 4) start = 1'b0;
      if (it == stall_at) stall_cnt = 10;
      if (fc2en && t_en < 0) t_en = cyc - k;
      if (out_valid && t_val < 0) t_val = cyc - k;
      if (out_valid && out_ready && out_final && t_fin < 0)
        t_fin = cyc - k;
      if (done) begin
        t_done = cyc - k;
        chk("busy_low_at_done", busy, 0);
        break;
      end
    end
    chk("done_seen", t_done >= 0, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("words_drained", exp_q.size(), 0);
    chk("addrs_drained", addr_q.size(), 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_fc2en"}, fc2en, 0);
    chk({tag, "_addr"}, fc2dataaddr, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_final"}, out_final, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    int te, tv, tf, td;
    int exp_mp[6];
    int exp_wr[4];
    seed = DW'($urandom);
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b0;

    run(0, 4, 1, -1, 0, te, tv, tf, td);
    chk("basic_t_en", te, 1);
    chk("basic_t_valid", tv, 3);
    chk("basic_t_final", tf, 6);
    chk("basic_t_done", td, 7);
    chk("basic_nreads", addr_log.size(), 4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++)
      chk("basic_addr", addr_log[i], i);
    if (last_log.size() == 4) begin
      chk("basic_last0", last_log[0], 0);
      chk("basic_last3", last_log[3], 1);
      chk("basic_final3", fin_log[3], 1);
    end else chk("basic_nwords", last_log.size(), 4);

    exp_mp = '{0, 1, 2, 0, 1, 2};
    run(0, 3, 2, -1, 0, te, tv, tf, td);
    chk("mp_t_done", td, 9);
    chk("mp_nreads", addr_log.size(), 6);
    for (int i = 0; i < 6 && i < addr_log.size(); i++)
      chk("mp_addr", addr_log[i], exp_mp[i]);
    if (last_log.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk("mp_last", last_log[i], (i == 2 || i == 5) ? 1 : 0);
        chk("mp_final", fin_log[i], (i == 5) ? 1 : 0);
      end
    end else chk("mp_nwords", last_log.size(), 6);

    run(37, 12, 2, 4, 0, te, tv, tf, td);

    exp_wr = '{16382, 16383, 0, 1};
    run(16382, 4, 1, -1, 0, te, tv, tf, td);
    chk("wrap_nreads", addr_log.size(), 4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++)
      chk("wrap_addr", addr_log[i], exp_wr[i]);

    run(5, 0, 3, -1, 0, te, tv, tf, td);
    chk("zlen_no_read", te, -1);
    chk("zlen_t_done", td, 2);
    run(5, 4, 0, -1, 0, te, tv, tf, td);
    chk("zpass_no_read", te, -1);
    chk("zpass_t_done", td, 2);

    run(100, 8, 1, -1, 1, te, tv, tf, td);
    chk("busy_start_nreads", addr_log.size(), 8);

    rnd_ready = 1;
    for (int r = 0; r < 8; r++) begin
      run($urandom_range(0, (1 << AW) - 1), $urandom_range(1, 10),
          $urandom_range(1, 3), $urandom_range(0, 12), 0,
          te, tv, tf, td);
    end
    rnd_ready = 0;

    @(negedge clk);
    stall_cnt = 1000;
    @(negedge clk);
    base_addr = AW'(50);
    vec_len   = AW'(3);
    passes    = 8'd1;
    start     = 1'b1;
    model_load(50, 3, 1);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("drain_busy", busy, 1);
    chk("drain_valid", out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_zero_outputs("midrst");
    exp_q.delete();
    addr_q.delete();
    stall_cnt = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_no_valid", out_valid, 0);
    run(0, 4, 1, -1, 0, te, tv, tf, td);
    chk("post_rst_t_done", td, 7);
    chk("post_rst_nreads", addr_log.size(), 4);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
